// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : RV32M execute-stage multiply/divide unit. Two-cycle multiply,
//               32-step restoring divider, stall while busy, 1-cycle done.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand classification at latch time
  logic            in_sdiv, in_div_zero, in_ovf;
  logic [XLEN-1:0] in_mag_a, in_mag_b, in_special;
  assign in_sdiv     = func3[2] & ~func3[0];
  assign in_div_zero = (op_b == '0);
  assign in_ovf      = in_sdiv & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  assign in_mag_a    = (in_sdiv & op_a[XLEN-1]) ? -op_a : op_a;
  assign in_mag_b    = (in_sdiv & op_b[XLEN-1]) ? -op_b : op_b;
  assign in_special  = func3[1] ? (in_div_zero ? op_a : '0)
                                : (in_div_zero ? '1   : op_a);

  // Multiplier: op_q 01=MULH (s*s), 10=MULHSU (s*u), 00/11 unsigned
  logic              mul_a_signed, mul_b_signed;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN-1:0]   mul_res;
  assign mul_a_signed = (op_q == 2'b01) | (op_q == 2'b10);
  assign mul_b_signed = (op_q == 2'b01);
  assign mul_a_ext    = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
  assign mul_b_ext    = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
  assign mul_prod     = mul_a_ext * mul_b_ext;
  assign mul_res      = (op_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // Restoring divide step: a_q shifts out dividend bits and collects quotient bits
  logic [XLEN:0]   rem_sh;
  logic            q_bit;
  logic [XLEN-1:0] rem_nx, quot_nx, quot_fin, rem_fin, div_res;
  assign rem_sh   = {rem_q, a_q[XLEN-1]};
  assign q_bit    = (rem_sh >= {1'b0, b_q});
  assign rem_nx   = q_bit ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
  assign quot_nx  = {a_q[XLEN-2:0], q_bit};
  assign quot_fin = neg_quot_q ? -quot_nx : quot_nx;
  assign rem_fin  = neg_rem_q  ? -rem_nx  : rem_nx;
  assign div_res  = op_q[1] ? rem_fin : quot_fin;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    stall      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start & ~flush) begin
          stall      = 1'b1;
          op_d       = func3[1:0];
          rem_d      = '0;
          cnt_d      = '0;
          neg_quot_d = in_sdiv & (op_a[XLEN-1] ^ op_b[XLEN-1]);
          neg_rem_d  = in_sdiv & op_a[XLEN-1];
          if (!func3[2]) begin
            state_d = S_MUL;
            a_d     = op_a;
            b_d     = op_b;
          end else if (in_div_zero | in_ovf) begin
            state_d  = S_DONE;
            result_d = in_special;
          end else begin
            state_d = S_DIV;
            a_d     = in_mag_a;
            b_d     = in_mag_b;
          end
        end
      end
      S_MUL: begin
        stall    = 1'b1;
        result_d = mul_res;
        state_d  = S_DONE;
      end
      S_DIV: begin
        stall = 1'b1;
        a_d   = quot_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          result_d = div_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A killed op leaves nothing behind; the last presented result survives
    if (flush) begin
      state_d    = S_IDLE;
      op_d       = '0;
      a_d        = '0;
      b_d        = '0;
      rem_d      = '0;
      cnt_d      = '0;
      neg_quot_d = 1'b0;
      neg_rem_d  = 1'b0;
      result_d   = result_q;
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire
